ps2_rx_frame: RTL and testbench

Receives the serial PS/2 device-to-host stream on the raw `ps2_clk`/`ps2_data` pins and produces one byte per frame for the controller datapath. The block synchronizes and glitch-filters the pins, then deserializes each 11-bit frame (start, 8 data bits LSB first, odd parity, stop). It presents each good byte through a valid/ack holding register, and that register feeds the controller's byte-select multiplexer. Framing errors and overruns are reported as one-cycle pulses.

---
 rtl/ps2_rx_frame.sv | 181 ++++++++++++++++++
 tb/tb_ps2_rx_frame.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_frame.sv
// rtl/ps2_rx_frame.sv - PS/2 device-to-host frame receiver; optional mid-frame timeout via PS2_RX_TIMEOUT_EN
module ps2_rx_frame #(
   parameter int DATA_WIDTH     = 8,
   parameter int SYNC_STAGES    = 2,
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 5000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ps2_clk,
   input  logic                  ps2_data,
   input  logic                  rx_ack,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  rx_err,
   output logic                  rx_overrun,
   output logic                  rx_busy
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] data_sync;
   logic                   clk_s;
   logic                   data_s;

   logic                   filt_clk;
   logic [FW-1:0]          filt_cnt;
   logic                   fall_evt;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]  shift_q, shift_d;
   logic                   par_q, par_d;
   logic                   err_d;
   logic                   deliver_d;

   // Pin synchronizers; idle-high pins so the chains reset to 1
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_sync  <= '1;
         data_sync <= '1;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
         data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      end
   end

   assign clk_s  = clk_sync[SYNC_STAGES-1];
   assign data_s = data_sync[SYNC_STAGES-1];

   // Clock filter: level changes only after FILTER_LEN consecutive differing samples
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         filt_clk <= 1'b1;
         filt_cnt <= '0;
      end else if (clk_s == filt_clk) begin
         filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
         filt_clk <= clk_s;
         filt_cnt <= '0;
      end else begin
         filt_cnt <= filt_cnt + 1'b1;
      end
   end

   // The fall event coincides with the edge on which the filtered clock drops,
   // so the synchronized data sampled here is the settled bit value.
   assign fall_evt = filt_clk & ~clk_s & (filt_cnt == FILT_LAST);

`ifdef PS2_RX_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);

   logic [TW-1:0] to_cnt;
   logic          timeout_hit;

   // Inactivity counter, restarted by every fall event and held clear while idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         to_cnt <= '0;
      end else if (state_q == S_IDLE || fall_evt) begin
         to_cnt <= '0;
      end else begin
         to_cnt <= to_cnt + 1'b1;
      end
   end

   assign timeout_hit = (state_q != S_IDLE) && (to_cnt == TO_LIMIT) && !fall_evt;
`endif

   // Frame state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         par_q   <= par_d;
      end
   end

   // Frame sequencing: advances on fall events, decides delivery or error at the stop bit
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shift_d   = shift_q;
      par_d     = par_q;
      err_d     = 1'b0;
      deliver_d = 1'b0;
      if (fall_evt) begin
         case (state_q)
            S_IDLE: begin
               if (!data_s) begin
                  state_d = S_DATA;
                  cnt_d   = '0;
               end
            end
            S_DATA: begin
               shift_d[cnt_q] = data_s;
               if (cnt_q == CNT_LAST) begin
                  state_d = S_PARITY;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_PARITY: begin
               par_d   = data_s;
               state_d = S_STOP;
            end
            S_STOP: begin
               // Odd parity: data bits plus parity bit must XOR to 1
               if (data_s && (^{shift_q, par_q})) begin
                  deliver_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
`ifdef PS2_RX_TIMEOUT_EN
      else if (timeout_hit) begin
         err_d   = 1'b1;
         state_d = S_IDLE;
      end
`endif
   end

   // Holding register and registered pulse outputs; errors leave the held byte intact
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         rx_err     <= 1'b0;
         rx_overrun <= 1'b0;
      end else begin
         rx_err     <= err_d;
         rx_overrun <= deliver_d & rx_valid & ~rx_ack;
         if (deliver_d) begin
            rx_data  <= shift_q;
            rx_valid <= 1'b1;
         end else if (rx_ack) begin
            rx_valid <= 1'b0;
         end
      end
   end

   assign rx_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_ps2_rx_frame.sv
// tb/tb_ps2_rx_frame.sv - self-checking bench for ps2_rx_frame
module tb_ps2_rx_frame;

   localparam int SYNC = 2;
   localparam int FILT = 4;
   localparam int TO   = 600;
   localparam int HALF = 20;

   logic       clk = 1'b0;
   logic       rst;
   logic       ps2_clk;
   logic       ps2_data;
   logic       rx_ack;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_err;
   logic       rx_overrun;
   logic       rx_busy;

   always #5 clk = ~clk;

   ps2_rx_frame #(
      .DATA_WIDTH(8),
      .SYNC_STAGES(SYNC),
      .FILTER_LEN(FILT),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .ps2_clk(ps2_clk),
      .ps2_data(ps2_data),
      .rx_ack(rx_ack),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .rx_err(rx_err),
      .rx_overrun(rx_overrun),
      .rx_busy(rx_busy)
   );

   typedef struct {
      logic [7:0] data;
      logic       err;
      logic       ovr;
   } exp_t;

   typedef struct {
      logic [7:0] b;
      logic       flip;
      logic       stop;
      logic       ack;
      logic [7:0] e_data;
      logic       e_err;
      logic       e_ovr;
      logic       e_valid;
   } vec_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Output monitor: each delivery or error event pops one expectation
   logic [7:0] prev_data  = 8'h00;
   logic       prev_valid = 1'b0;
   logic       prev_err   = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         prev_data  = 8'h00;
         prev_valid = 1'b0;
         prev_err   = 1'b0;
      end else begin
         if (prev_err) check("err_one_cycle", rx_err, 0);
         if (rx_err || rx_overrun || (rx_valid && !prev_valid) || (rx_data != prev_data)) begin
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_event: data 0x%0h err %0b ovr %0b, expected no event",
                        rx_data, rx_err, rx_overrun);
            end else begin
               e = sb.pop_front();
               check("sb_data", rx_data, e.data);
               check("sb_err", rx_err, e.err);
               check("sb_ovr", rx_overrun, e.ovr);
            end
         end
         prev_data  = rx_data;
         prev_valid = rx_valid;
         prev_err   = rx_err;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic ps2_bit(input logic b, input logic glitch);
      ps2_data = b;
      cyc(HALF);
      ps2_clk = 1'b0;
      cyc(HALF);
      ps2_clk = 1'b1;
      if (glitch) begin
         cyc(HALF);
         ps2_clk = 1'b0;
         cyc(FILT - 1);
         ps2_clk = 1'b1;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop,
                             input int nbits, input int glitch_after);
      logic [10:0] f;
      f = {stop, (~^b) ^ par_flip, b, 1'b0};
      for (int i = 0; i < nbits; i++) ps2_bit(f[i], i == glitch_after);
      ps2_data = 1'b1;
   endtask

   task automatic wait_drain(input string name, input int limit);
      int k;
      k = 0;
      while (sb.size() != 0 && k < limit) begin
         cyc(1);
         k++;
      end
      check(name, sb.size(), 0);
      if (sb.size() != 0) sb.delete();
   endtask

   task automatic ack_pulse();
      rx_ack = 1'b1;
      cyc(1);
      rx_ack = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[7];
      logic busy_seen;

      vt[0] = '{8'h1C, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
      vt[1] = '{8'h1C, 1'b0, 1'b1, 1'b0, 8'h1C, 1'b0, 1'b0, 1'b1};
      vt[2] = '{8'hF0, 1'b0, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b1};
      vt[3] = '{8'h1C, 1'b0, 1'b1, 1'b0, 8'h1C, 1'b0, 1'b1, 1'b1};
      vt[4] = '{8'h00, 1'b0, 1'b0, 1'b0, 8'h1C, 1'b1, 1'b0, 1'b1};
      vt[5] = '{8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1};
      vt[6] = '{8'h80, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1};

      rst      = 1'b1;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      rx_ack   = 1'b0;
      cyc(5);
      rst = 1'b0;
      cyc(2);
      check("reset_data", rx_data, 0);
      check("reset_valid", rx_valid, 0);
      check("reset_err", rx_err, 0);
      check("reset_ovr", rx_overrun, 0);
      check("reset_busy", rx_busy, 0);

      for (int i = 0; i < 7; i++) begin
         if (vt[i].ack) begin
            ack_pulse();
            cyc(2);
         end
         sb.push_back('{vt[i].e_data, vt[i].e_err, vt[i].e_ovr});
         send_frame(vt[i].b, vt[i].flip, vt[i].stop, 11, -1);
         wait_drain($sformatf("vec%0d_event", i), 100);
         check($sformatf("vec%0d_valid", i), rx_valid, vt[i].e_valid);
         check($sformatf("vec%0d_busy", i), rx_busy, 0);
         cyc(HALF);
      end

      ack_pulse();
      check("ack_clears_valid", rx_valid, 0);
      ack_pulse();
      check("ack_when_empty", rx_valid, 0);
      check("ack_keeps_data", rx_data, 8'hFF);

      ps2_clk = 1'b0;
      cyc(FILT - 1);
      ps2_clk = 1'b1;
      busy_seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         busy_seen = busy_seen | rx_busy;
      end
      check("glitch_idle_busy", busy_seen, 0);

      sb.push_back('{8'h5A, 1'b0, 1'b0});
      send_frame(8'h5A, 1'b0, 1'b1, 11, 3);
      wait_drain("glitch_frame_event", 100);
      check("glitch_frame_valid", rx_valid, 1);
      cyc(HALF);

`ifdef PS2_RX_TIMEOUT_EN
      ack_pulse();
      cyc(2);
      sb.push_back('{8'h5A, 1'b1, 1'b0});
      send_frame(8'hC3, 1'b0, 1'b1, 5, -1);
      wait_drain("timeout_event", 2 * TO);
      check("timeout_busy", rx_busy, 0);
      check("timeout_valid", rx_valid, 0);
      cyc(HALF);
      sb.push_back('{8'h55, 1'b0, 1'b0});
      send_frame(8'h55, 1'b0, 1'b1, 11, -1);
      wait_drain("after_timeout_event", 100);
      check("after_timeout_valid", rx_valid, 1);
      cyc(HALF);
`endif

      send_frame(8'h33, 1'b0, 1'b1, 6, -1);
      check("midframe_busy", rx_busy, 1);
      rst = 1'b1;
      #2;
      check("midreset_data", rx_data, 0);
      check("midreset_valid", rx_valid, 0);
      check("midreset_err", rx_err, 0);
      check("midreset_ovr", rx_overrun, 0);
      check("midreset_busy", rx_busy, 0);
      cyc(3);
      rst = 1'b0;
      cyc(HALF);

      sb.push_back('{8'hAA, 1'b0, 1'b0});
      send_frame(8'hAA, 1'b0, 1'b1, 11, -1);
      wait_drain("after_reset_event", 100);
      check("after_reset_valid", rx_valid, 1);
      cyc(HALF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
